// File: rtl/movwide_seq.sv
// movwide_seq: turns a 64-bit constant into the LEGv8 MOVZ/MOVK word stream that loads it
module movwide_seq #(
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] imm,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        instr_last
);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t      state, state_n;
   logic [63:0] imm_q, imm_n;
   logic [4:0]  rd_q, rd_n;
   logic [3:0]  mask_q, mask_n, raw_mask, start_mask, rest;
   logic [31:0] instr_n;
   logic        last_n, valid_n;
   // lowest pending halfword index
   function automatic logic [1:0] low_hw(input logic [3:0] m);
      return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
   endfunction
   // clear the lowest set bit
   function automatic logic [3:0] drop_low(input logic [3:0] m);
      return m & (m - 4'd1);
   endfunction
   // bit 29 selects MOVK over MOVZ; the remaining opcode bits are shared
   function automatic logic [31:0] enc(input logic movk, input logic [1:0] hw,
                                       input logic [63:0] v, input logic [4:0] r);
      return {2'b11, movk, 6'b100101, hw, v[{hw, 4'b0000} +: 16], r};
   endfunction
   assign raw_mask   = SKIP_ZERO ? {imm[63:48] != 16'd0, imm[47:32] != 16'd0,
                                    imm[31:16] != 16'd0, imm[15:0] != 16'd0} : 4'b1111;
   assign start_mask = (raw_mask == 4'b0000) ? 4'b0001 : raw_mask;
   assign rest       = drop_low(mask_q);
   // next-state and next registered outputs; handshake retires the current halfword
   always_comb begin
      state_n = state;
      imm_n   = imm_q;
      rd_n    = rd_q;
      mask_n  = mask_q;
      instr_n = instr;
      last_n  = instr_last;
      valid_n = instr_valid;
      if (state == IDLE && start) begin
         state_n = EMIT;
         imm_n   = imm;
         rd_n    = rd;
         mask_n  = start_mask;
         instr_n = enc(1'b0, low_hw(start_mask), imm, rd);
         last_n  = drop_low(start_mask) == 4'b0000;
         valid_n = 1'b1;
      end else if (state == EMIT && instr_ready) begin
         state_n = instr_last ? IDLE : EMIT;
         mask_n  = instr_last ? 4'b0000 : rest;
         instr_n = instr_last ? 32'd0 : enc(1'b1, low_hw(rest), imm_q, rd_q);
         last_n  = instr_last ? 1'b0 : drop_low(rest) == 4'b0000;
         valid_n = !instr_last;
      end
   end
   // state and output registers; reset aborts any sequence in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         imm_q       <= '0;
         rd_q        <= '0;
         mask_q      <= '0;
         instr       <= '0;
         instr_last  <= 1'b0;
         instr_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         imm_q       <= imm_n;
         rd_q        <= rd_n;
         mask_q      <= mask_n;
         instr       <= instr_n;
         instr_last  <= last_n;
         instr_valid <= valid_n;
         busy        <= valid_n;
      end
   end
endmodule

// File: tb/tb_movwide_seq.sv
// tb_movwide_seq: randomized check of both SKIP_ZERO variants against a halfword-level model
module tb_movwide_seq;
   logic        clock = 1'b0, reset = 1'b1, start = 1'b0, instr_ready = 1'b0;
   logic [63:0] imm = '0;
   logic [4:0]  rd = '0;
   logic [1:0]  busy, instr_valid, instr_last;
   logic [31:0] instr [2];
   int checks = 0, errors = 0;
   logic [32:0] exp_w [2][4];
   int          exp_n [2], exp_i [2];
   logic        stalled [2], pend_idle [2];
   logic [32:0] held [2];

   movwide_seq #(.SKIP_ZERO(1'b1)) u_skip (
      .clock(clock), .reset(reset), .start(start), .imm(imm), .rd(rd),
      .busy(busy[0]), .instr(instr[0]), .instr_valid(instr_valid[0]),
      .instr_ready(instr_ready), .instr_last(instr_last[0]));
   movwide_seq #(.SKIP_ZERO(1'b0)) u_full (
      .clock(clock), .reset(reset), .start(start), .imm(imm), .rd(rd),
      .busy(busy[1]), .instr(instr[1]), .instr_valid(instr_valid[1]),
      .instr_ready(instr_ready), .instr_last(instr_last[1]));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
      end
   endtask

   // expected word list: {last, word}; dut 1 never skips
   function automatic void model(input int d, input logic [63:0] v, input logic [4:0] r);
      int n = 0;
      logic [15:0] h;
      for (int i = 0; i < 4; i++) begin
         h = v[16*i +: 16];
         if (d == 1 || h != 16'd0) begin
            exp_w[d][n] = {1'b0, (n == 0) ? 9'h1A5 : 9'h1E5, 2'(i), h, r};
            n++;
         end
      end
      if (n == 0) begin
         exp_w[d][0] = {1'b0, 9'h1A5, 2'd0, 16'd0, r};
         n = 1;
      end
      exp_w[d][n-1][32] = 1'b1;
      exp_n[d] = n;
      exp_i[d] = 0;
   endfunction

   // consumer-side monitor: every handshake must match the next expected word
   initial begin
      stalled = '{1'b0, 1'b0};
      pend_idle = '{1'b0, 1'b0};
      forever begin
         @(negedge clock);
         if (reset) begin
            stalled = '{1'b0, 1'b0};
            pend_idle = '{1'b0, 1'b0};
         end else begin
            for (int d = 0; d < 2; d++) begin
               if (pend_idle[d]) begin
                  chk("idle_after_last", {30'd0, busy[d], instr_valid[d]}, 32'd0);
                  pend_idle[d] = 1'b0;
               end
               if (instr_valid[d]) begin
                  if (stalled[d]) begin
                     chk("hold_instr", instr[d], held[d][31:0]);
                     chk("hold_last", 32'(instr_last[d]), 32'(held[d][32]));
                  end
                  if (instr_ready) begin
                     if (exp_i[d] < exp_n[d]) begin
                        chk("word", instr[d], exp_w[d][exp_i[d]][31:0]);
                        chk("last", 32'(instr_last[d]), 32'(exp_w[d][exp_i[d]][32]));
                        if (exp_w[d][exp_i[d]][32]) pend_idle[d] = 1'b1;
                        exp_i[d]++;
                     end else begin
                        chk("extra_word", 32'(instr_valid[d]), 32'd0);
                     end
                     stalled[d] = 1'b0;
                  end else begin
                     stalled[d] = 1'b1;
                     held[d] = {instr_last[d], instr[d]};
                  end
               end else begin
                  stalled[d] = 1'b0;
               end
            end
         end
      end
   end

   // mode 0: ready high, 1: random ready, 2: five stall cycles per word; poke restarts while busy
   task automatic run(input logic [63:0] v, input logic [4:0] r, input int mode, input bit poke);
      int c = 0;
      int longest;
      model(0, v, r);
      model(1, v, r);
      longest = (exp_n[0] > exp_n[1]) ? exp_n[0] : exp_n[1];
      @(posedge clock); #1;
      imm = v;
      rd = r;
      start = 1'b1;
      instr_ready = (mode == 0);
      @(posedge clock); #1;
      chk("first_valid", {28'd0, busy, instr_valid}, 32'hF);
      if (poke) begin
         imm = ~v ^ {$urandom, $urandom};
         rd = r + 5'd1;
         @(posedge clock); #1;
      end
      start = 1'b0;
      while (!(exp_i[0] == exp_n[0] && exp_i[1] == exp_n[1] && busy == 2'b00) && c < 300) begin
         instr_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : (c % 6 == 5);
         @(posedge clock); #1;
         c++;
      end
      chk("timeout", 32'(c < 300), 32'd1);
      if (mode == 0) chk("no_bubble", 32'(c + int'(poke)), 32'(longest));
      @(negedge clock);
   endtask

   task automatic reset_mid;
      logic [63:0] v;
      v = {$urandom, $urandom} | 64'h0001_0001_0001_0001;
      model(0, v, 5'd9);
      model(1, v, 5'd9);
      @(posedge clock); #1;
      imm = v;
      rd = 5'd9;
      start = 1'b1;
      instr_ready = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("pre_reset_words", 32'(exp_i[d]), 32'd1);
         chk("rst_mid_instr", instr[d], 32'd0);
         chk("rst_mid_ctl", {29'd0, busy[d], instr_valid[d], instr_last[d]}, 32'd0);
         exp_n[d] = exp_i[d];
      end
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         chk("no_resume", {30'd0, instr_valid}, 32'd0);
      end
   endtask

   initial begin
      logic [63:0] v;
      exp_n = '{0, 0};
      exp_i = '{0, 0};
      repeat (3) @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_instr", instr[d], 32'd0);
         chk("rst_ctl", {29'd0, busy[d], instr_valid[d], instr_last[d]}, 32'd0);
      end
      reset = 1'b0;
      run(64'h0000_0000_0000_1234, 5'd3, 0, 1'b0);
      run(64'h1234_0000_5678_0000, 5'd7, 0, 1'b0);
      run(64'h0, 5'd31, 0, 1'b0);
      run(64'h1234_0000_5678_0000, 5'd7, 2, 1'b0);
      run(64'h1, 5'd0, 0, 1'b0);
      run(64'h1234_0000_5678_0000, 5'd7, 0, 1'b1);
      run(64'h1234_0000_5678_0000, 5'd7, 1, 1'b1);
      reset_mid();
      run(64'hDEAD_0000_BEEF_0042, 5'd5, 1, 1'b0);
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 4; i++) v[16*i +: 16] = ($urandom % 2) ? 16'($urandom) : 16'd0;
         run(v, 5'($urandom), $urandom % 3, ($urandom % 4) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
